// File: rtl/alu_ops_pkg.sv
// alu_ops: shared definitions for the ALU result path.
//   FLAG_N/Z/C/V : bit positions of the flags inside a 4-bit {N,Z,C,V} vector
//   alu_flags_t  : packed flag struct, same bit order as the vector form
// The width-dependent result entry type is declared in alu_result_stage,
// because it is sized by that module's w parameter.
package alu_ops;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: 2-entry buffer for captured ALU results.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of count and pointers
//   push_i     : write wdata_i at the tail (caller guarantees not full)
//   pop_i      : drop the head entry (caller guarantees not empty)
//   rdata_o    : head entry while non-empty, otherwise the last head shown
//   count_o    : number of valid entries (0..2)
module alu_result_fifo #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] hold_q;
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push_i) wr_ptr_q <= ~wr_ptr_q;
                if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage needs no reset: it is never shown until written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Remembers the head on display so the output holds once the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (count_q != 2'd0) begin
            hold_q <= mem_q[rd_ptr_q];
        end
    end

    assign rdata_o = (count_q != 2'd0) ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered stage behind the combinational ALU.
// Captures {opcode, y, N, Z, C, V} into a 2-entry buffer under valid/ready,
// and commits the head flags into the NZCV status register when popped.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   flush                            : discard buffered results (no commit)
//   in_valid/in_ready                : producer handshake
//   in_opcode, in_y, in_c_out, in_v  : ALU result
//   out_valid/out_ready              : consumer handshake
//   out_opcode, out_y, out_flags     : head entry ({N,Z,C,V})
//   flags_q                          : committed status register {N,Z,C,V}
//   carry_fb                         : committed C, back to ALU c_in
// Optional: ALU_RESULT_STICKY_V_EN adds sticky_clr (in) and sticky_v (out),
// a sticky overflow bit set by any commit with V=1.
module alu_result_stage
    import alu_ops::*;
#(
    parameter int unsigned w = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [w-1:0] in_opcode,
    input  logic [w-1:0] in_y,
    input  logic         in_c_out,
    input  logic         in_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_opcode,
    output logic [w-1:0] out_y,
    output logic [3:0]   out_flags,
`ifdef ALU_RESULT_STICKY_V_EN
    input  logic         sticky_clr,
    output logic         sticky_v,
`endif
    output logic [3:0]   flags_q,
    output logic         carry_fb
);

    typedef struct packed {
        logic [w-1:0] opcode;
        logic [w-1:0] y;
        alu_flags_t   flags;
    } alu_result_t;

    alu_result_t in_entry, head;
    logic [1:0]  count;
    logic        push, pop, commit;
    logic [3:0]  flags_d;

    // Flags are derived at capture so the buffer holds final values.
    always_comb begin
        in_entry.opcode  = in_opcode;
        in_entry.y       = in_y;
        in_entry.flags.n = in_y[w-1];
        in_entry.flags.z = (in_y == '0);
        in_entry.flags.c = in_c_out;
        in_entry.flags.v = in_v;
    end

    assign in_ready  = (count < 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // A pop during flush discards rather than commits.
    assign commit    = pop && !flush;

    alu_result_fifo #(
        .Width($bits(alu_result_t))
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(in_entry),
        .rdata_o(head),
        .count_o(count)
    );

    assign out_opcode = head.opcode;
    assign out_y      = head.y;
    assign out_flags  = head.flags;

    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            flags_d[FLAG_N] = head.flags.n;
            flags_d[FLAG_Z] = head.flags.z;
            flags_d[FLAG_C] = head.flags.c;
            flags_d[FLAG_V] = head.flags.v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    assign carry_fb = flags_q[FLAG_C];

`ifdef ALU_RESULT_STICKY_V_EN
    logic sticky_d;

    // A set in the same cycle as a clear wins.
    always_comb begin
        sticky_d = sticky_v;
        if (commit && head.flags.v) sticky_d = 1'b1;
        else if (sticky_clr)        sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_v <= 1'b0;
        else        sticky_v <= sticky_d;
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (w=3). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_alu_result_stage;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush, in_valid, in_ready, in_c_out, in_v;
    logic [W-1:0] in_opcode, in_y;
    logic         out_valid, out_ready;
    logic [W-1:0] out_opcode, out_y;
    logic [3:0]   out_flags, flags_q;
    logic         carry_fb;
    logic         sticky_clr, sticky_v;

    alu_result_stage #(
        .w(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_y      (in_y),
        .in_c_out  (in_c_out),
        .in_v      (in_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opcode(out_opcode),
        .out_y     (out_y),
        .out_flags (out_flags),
`ifdef ALU_RESULT_STICKY_V_EN
        .sticky_clr(sticky_clr),
        .sticky_v  (sticky_v),
`endif
        .flags_q   (flags_q),
        .carry_fb  (carry_fb)
    );

`ifndef ALU_RESULT_STICKY_V_EN
    assign sticky_v = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] op;
        logic [W-1:0] y;
        logic [3:0]   f;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [3:0]   m_flags;
    logic         m_sticky;
    logic [W-1:0] last_op, last_y;
    logic [3:0]   last_f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [W-1:0] y, input logic c, input logic v);
        return {y[W-1], (y == '0), c, v};
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_flags  = 4'b0000;
        m_sticky = 1'b0;
        last_op  = '0;
        last_y   = '0;
        last_f   = '0;
    endfunction

    // One clock of the model against the DUT, with inputs already driven.
    task automatic step();
        logic exp_ready, do_push, do_pop;
        exp_t e;
        @(negedge clk);
        exp_ready = (sb.size() < 2) && !flush;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            last_op = sb[0].op;
            last_y  = sb[0].y;
            last_f  = sb[0].f;
        end
        check("out_y", 32'(out_y), 32'(last_y));
        check("out_opcode", 32'(out_opcode), 32'(last_op));
        check("out_flags", 32'(out_flags), 32'(last_f));
        do_push = in_valid && exp_ready;
        do_pop  = (sb.size() != 0) && out_ready;
        if (flush) begin
            sb.delete();
            if (sticky_clr) m_sticky = 1'b0;
        end else begin
            if (do_pop) begin
                m_flags = sb[0].f;
                if (sb[0].f[0])      m_sticky = 1'b1;
                else if (sticky_clr) m_sticky = 1'b0;
                void'(sb.pop_front());
            end else if (sticky_clr) begin
                m_sticky = 1'b0;
            end
            if (do_push) begin
                e.op = in_opcode;
                e.y  = in_y;
                e.f  = flags_of(in_y, in_c_out, in_v);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("flags_q", 32'(flags_q), 32'(m_flags));
        check("carry_fb", 32'(carry_fb), 32'(m_flags[1]));
`ifdef ALU_RESULT_STICKY_V_EN
        check("sticky_v", 32'(sticky_v), 32'(m_sticky));
`endif
    endtask

    task automatic drive(input logic v, input logic [W-1:0] y, input logic c, input logic ov,
                         input logic rdy);
        in_valid  = v;
        in_y      = y;
        in_c_out  = c;
        in_v      = ov;
        in_opcode = W'($urandom);
        out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags_q", 32'(flags_q), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // 1: zero result with carry: flags 0110, committed next cycle.
        drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t1_out_flags", 32'(out_flags), 32'b0110);
        step();
        check("t1_flags_q", 32'(flags_q), 32'b0110);
        check("t1_carry_fb", 32'(carry_fb), 32'd1);

        // 2: fill, back-pressure, then drain in order.
        drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        step();
        check("t2_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t2_first", 32'(out_y), 32'b101);
        step();
        check("t2_second", 32'(out_y), 32'b010);
        step();
        check("t2_ready_back", 32'(in_ready), 32'd1);

        // 3: push and pop together at count 1.
        drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        check("t3_count1", 32'(out_valid), 32'd1);
        check("t3_head", 32'(out_y), 32'b001);
        check("t3_flags_q", 32'(flags_q), 32'b1000);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();

        // 4: flush with two entries and a pending pop: no commit.
        drive(1'b1, 3'b010, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'b110, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'b100, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        #1 check("t4_ready_flush", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_flags_q", 32'(flags_q), 32'b0010);
        step();

        // 5: asynchronous reset with two entries buffered.
        drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_flags_q", 32'(flags_q), 32'd0);
        model_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

`ifdef ALU_RESULT_STICKY_V_EN
        // 6: sticky overflow.
        drive(1'b1, 3'b011, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        check("t6_set", 32'(sticky_v), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        check("t6_keep", 32'(sticky_v), 32'd1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("t6_clear", 32'(sticky_v), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0));
            flush      = ($urandom_range(0, 19) == 0);
            sticky_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0;
        sticky_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
